// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-lite arbiter: CPU is the default master, DMAC wins contention but its
// tenure is bounded while the CPU waits, followed by a short CPU-only slot.
module ahb_bus_arbiter #(
    parameter int MAX_DMA_HOLD = 16,
    parameter int CPU_SLOT     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic Cpu_Req,
    input  logic Bus_Req,
    input  logic HReady,
    output logic Cpu_Grant,
    output logic Bus_Grant,
    output logic HMaster,
    output logic HMaster_Data,
    output logic Preempt
);

    localparam int HOLD_W = (MAX_DMA_HOLD > 0) ? $clog2(MAX_DMA_HOLD + 1) : 1;
    localparam int COOL_W = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MAX_DMA_HOLD);
    localparam logic [COOL_W-1:0] COOL_LOAD  = COOL_W'(CPU_SLOT);
    localparam logic              PREEMPT_EN = (MAX_DMA_HOLD != 0);

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } state_t;

    state_t              state_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [COOL_W-1:0]   cool_cnt_r;
    logic                cpu_grant_r;
    logic                bus_grant_r;
    logic                hmaster_r;
    logic                hmaster_data_r;
    logic                preempt_r;

    logic                grant_dma_s;
    logic                release_vol_s;
    logic                release_force_s;

    // Ownership decisions for the coming edge; voluntary release takes priority over preemption
    always_comb begin
        grant_dma_s     = 1'b0;
        release_vol_s   = 1'b0;
        release_force_s = 1'b0;
        case (state_r)
            CPU_OWN: begin
                grant_dma_s = HReady && Bus_Req && (cool_cnt_r == {COOL_W{1'b0}});
            end
            DMA_OWN: begin
                if (HReady && !Bus_Req) begin
                    release_vol_s = 1'b1;
                end else if (HReady && PREEMPT_EN && Cpu_Req && (hold_cnt_r >= HOLD_MAX)) begin
                    release_force_s = 1'b1;
                end else begin
                    release_vol_s   = 1'b0;
                    release_force_s = 1'b0;
                end
            end
            default: begin
                grant_dma_s     = 1'b0;
                release_vol_s   = 1'b0;
                release_force_s = 1'b0;
            end
        endcase
    end

    // Arbiter FSM, tenure/cooldown counters and registered bus-owner outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= CPU_OWN;
            hold_cnt_r     <= {HOLD_W{1'b0}};
            cool_cnt_r     <= {COOL_W{1'b0}};
            cpu_grant_r    <= 1'b1;
            bus_grant_r    <= 1'b0;
            hmaster_r      <= 1'b0;
            hmaster_data_r <= 1'b0;
            preempt_r      <= 1'b0;
        end else begin
            case (state_r)
                CPU_OWN: begin
                    if (grant_dma_s) begin
                        state_r     <= DMA_OWN;
                        cpu_grant_r <= 1'b0;
                        bus_grant_r <= 1'b1;
                        hmaster_r   <= 1'b1;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                    end else begin
                        state_r     <= CPU_OWN;
                    end
                end
                DMA_OWN: begin
                    if (release_vol_s || release_force_s) begin
                        state_r     <= CPU_OWN;
                        cpu_grant_r <= 1'b1;
                        bus_grant_r <= 1'b0;
                        hmaster_r   <= 1'b0;
                    end else if (Cpu_Req && (hold_cnt_r < HOLD_MAX)) begin
                        hold_cnt_r  <= hold_cnt_r + HOLD_W'(1);
                    end else begin
                        state_r     <= DMA_OWN;
                    end
                end
                default: begin
                    state_r     <= CPU_OWN;
                    cpu_grant_r <= 1'b1;
                    bus_grant_r <= 1'b0;
                    hmaster_r   <= 1'b0;
                end
            endcase

            preempt_r <= release_force_s;

            // The CPU slot counts down every cycle, independent of bus stalls
            if (release_force_s) begin
                cool_cnt_r <= COOL_LOAD;
            end else if (cool_cnt_r != {COOL_W{1'b0}}) begin
                cool_cnt_r <= cool_cnt_r - COOL_W'(1);
            end else begin
                cool_cnt_r <= cool_cnt_r;
            end

            if (HReady) begin
                hmaster_data_r <= hmaster_r;
            end else begin
                hmaster_data_r <= hmaster_data_r;
            end
        end
    end

    assign Cpu_Grant    = cpu_grant_r;
    assign Bus_Grant    = bus_grant_r;
    assign HMaster      = hmaster_r;
    assign HMaster_Data = hmaster_data_r;
    assign Preempt      = preempt_r;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: the driver queues hand-computed output vectors
// {Cpu_Grant, Bus_Grant, HMaster, HMaster_Data, Preempt}; the monitor pops one per clock.
module tb_ahb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic Cpu_Req = 1'b0;
    logic Bus_Req = 1'b0;
    logic HReady = 1'b0;
    logic Cpu_Grant, Bus_Grant, HMaster, HMaster_Data, Preempt;

    logic rst_next = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [4:0] v;
        string      nm;
    } exp_t;
    exp_t q[$];

    localparam logic [4:0] CPU_IDLE = 5'b10000;
    localparam logic [4:0] CPU_HD1  = 5'b10010;
    localparam logic [4:0] CPU_PRE  = 5'b10011;
    localparam logic [4:0] DMA_HD0  = 5'b01100;
    localparam logic [4:0] DMA_HD1  = 5'b01110;

    ahb_bus_arbiter #(.MAX_DMA_HOLD(16), .CPU_SLOT(4)) dut (
        .clk(clk), .rst(rst), .Cpu_Req(Cpu_Req), .Bus_Req(Bus_Req), .HReady(HReady),
        .Cpu_Grant(Cpu_Grant), .Bus_Grant(Bus_Grant), .HMaster(HMaster),
        .HMaster_Data(HMaster_Data), .Preempt(Preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {cg,bg,hm,hd,pre}=%b expected %b", nm, act, exp);
        end
    endtask

    // One clock of stimulus plus the outputs expected after the following rising edge
    task automatic drive(input logic cr, input logic br, input logic hr,
                         input logic [4:0] ev, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = rst_next;
        Cpu_Req = cr;
        Bus_Req = br;
        HReady  = hr;
        e.v  = ev;
        e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: compares DUT outputs shortly after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.nm, {Cpu_Grant, Bus_Grant, HMaster, HMaster_Data, Preempt}, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held, then released with no requests
        rst_next = 1'b0;
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, CPU_IDLE, $sformatf("rst_hold%0d", i));
        rst_next = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, CPU_IDLE, $sformatf("t1_idle%0d", i));

        // Grant, data-phase lag, voluntary release and immediate re-grant
        drive(1'b0, 1'b1, 1'b1, DMA_HD0,  "t2_grant");
        drive(1'b0, 1'b1, 1'b1, DMA_HD1,  "t2_data_owner");
        drive(1'b0, 1'b0, 1'b1, CPU_HD1,  "t5_release");
        drive(1'b0, 1'b1, 1'b1, DMA_HD0,  "t5_regrant");
        drive(1'b0, 1'b0, 1'b1, CPU_HD1,  "t5_release2");
        drive(1'b0, 1'b0, 1'b1, CPU_IDLE, "t5_idle");

        // Stalled bus holds ownership and data-phase owner
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, CPU_IDLE, $sformatf("t3_stall%0d", i));
        drive(1'b0, 1'b1, 1'b1, DMA_HD0,  "t3_grant");
        drive(1'b0, 1'b1, 1'b0, DMA_HD0,  "t3_hd_hold");
        drive(1'b0, 1'b1, 1'b1, DMA_HD1,  "t3_hd_adv");
        drive(1'b0, 1'b0, 1'b0, DMA_HD1,  "t3_rel_stalled");
        drive(1'b0, 1'b0, 1'b1, CPU_HD1,  "t3_release");
        drive(1'b0, 1'b0, 1'b1, CPU_IDLE, "t3_idle");

        // Forced preemption after hold_cnt reaches 16, then 4-cycle CPU slot
        drive(1'b1, 1'b1, 1'b1, DMA_HD0, "t4_grant");
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b1, 1'b1, DMA_HD1, $sformatf("t4_hold%0d", i));
        drive(1'b1, 1'b1, 1'b1, CPU_PRE, "t4_preempt");
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, CPU_IDLE, $sformatf("t4_cool%0d", i));
        drive(1'b1, 1'b1, 1'b1, DMA_HD0, "t4_regrant");

        // Release coinciding with preemption is voluntary: no pulse, no cooldown
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b1, 1'b1, DMA_HD1, $sformatf("sim_hold%0d", i));
        drive(1'b1, 1'b0, 1'b1, CPU_HD1, "sim_release");
        drive(1'b1, 1'b1, 1'b1, DMA_HD0, "sim_regrant");

        // hold_cnt saturates and waits while the CPU is not requesting
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b1, 1'b1, DMA_HD1, $sformatf("sat_hold%0d", i));
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, DMA_HD1, $sformatf("sat_nocpu%0d", i));
        drive(1'b1, 1'b1, 1'b1, CPU_PRE, "sat_preempt");
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, CPU_IDLE, $sformatf("sat_cool%0d", i));
        drive(1'b0, 1'b1, 1'b1, DMA_HD0, "sat_regrant");
        drive(1'b0, 1'b1, 1'b1, DMA_HD1, "t6_dma");
        drive(1'b0, 1'b1, 1'b0, DMA_HD1, "t6_stall");

        // Asynchronous reset mid-cycle during a stalled DMA tenure
        @(posedge clk);
        #3;
        rst      = 1'b0;
        rst_next = 1'b0;
        #1;
        check("t6_async_rst", {Cpu_Grant, Bus_Grant, HMaster, HMaster_Data, Preempt}, CPU_IDLE);
        drive(1'b0, 1'b1, 1'b0, CPU_IDLE, "t6_rst_held");
        rst_next = 1'b1;
        drive(1'b0, 1'b0, 1'b1, CPU_IDLE, "t6_after0");
        drive(1'b0, 1'b0, 1'b1, CPU_IDLE, "t6_after1");

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
